uart_rx_multi: RTL

Parametrised successor to the team's fixed-format serial receiver. Receives asynchronous UART frames with configurable data width, parity mode and stop-bit count, and oversamples `rx` on an external tick for mid-bit sampling and false-start rejection. Delivers each frame on a valid/ack handshake with per-frame parity, framing and overrun flags. Sits between the pad-side `rx` line and the core-side consumer; the baud/oversample tick comes from a shared baud generator.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_rx_multi.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchroniser (2 flops, reset to idle-high); with UART_RX_MAJORITY_EN, bit_val is a 2-of-3 vote
// over the last three rx_en ticks, otherwise bit_val = rx_s. Latency 2 clk; no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
`ifdef UART_RX_MAJORITY_EN
  input  logic rx_en,
`endif
  output logic rx_s,
  output logic bit_val
);

  logic rx_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] = rx_s at previous tick (centre), hist[1] = two ticks back (centre-1)
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (rx_en) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_multi.sv
// Parametrised UART receiver (optional UART_RX_MAJORITY_EN vote); data_valid rises 1 clk after the
// last stop-bit sample tick. Frames arriving while data_valid is held are dropped and flag overrun.
module uart_rx_multi #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int TW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DLY = 1;
`else
  localparam int MAJ_DLY = 0;
`endif
  // The vote completes one tick after centre; shifting the start decision shifts every later bit too.
  localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2 - 1 + MAJ_DLY);
  localparam logic [TW-1:0] T_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP  = BW'(STOP_BITS - 1);

  state_t               state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sr;
  logic                 pe_r;
  logic                 fe_r;
  logic                 rx_s;
  logic                 bit_val;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
`ifdef UART_RX_MAJORITY_EN
    .rx_en   (rx_en),
`endif
    .rx_s    (rx_s),
    .bit_val (bit_val)
  );

  logic [TW-1:0] tcnt_nx;
  logic          at_bit;
  logic          done;
  logic          fe_fin;
  logic          par_x;

  assign tcnt_nx = (tcnt == T_BIT) ? '0 : tcnt + TW'(1);
  assign at_bit  = rx_en && (tcnt == T_BIT);
  assign done    = at_bit && (state == STOP) && (bcnt == B_STOP);
  assign fe_fin  = fe_r | ~bit_val;
  assign par_x   = (^sr) ^ bit_val;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      bcnt         <= '0;
      sr           <= '0;
      pe_r         <= 1'b0;
      fe_r         <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (rx_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              tcnt  <= '0;
            end
          end
          START: begin
            if (tcnt == T_START) begin
              tcnt <= '0;
              bcnt <= '0;
              state <= bit_val ? IDLE : DATA;
            end else begin
              tcnt <= tcnt_nx;
            end
          end
          DATA: begin
            tcnt <= tcnt_nx;
            if (tcnt == T_BIT) begin
              sr <= {bit_val, sr[DATA_BITS-1:1]};
              if (bcnt == B_DATA) begin
                bcnt  <= '0;
                pe_r  <= 1'b0;
                fe_r  <= 1'b0;
                state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end
          end
          PARITY: begin
            tcnt <= tcnt_nx;
            if (tcnt == T_BIT) begin
              pe_r  <= (PARITY_MODE == PAR_ODD) ? ~par_x : par_x;
              state <= STOP;
            end
          end
          STOP: begin
            tcnt <= tcnt_nx;
            if (tcnt == T_BIT) begin
              fe_r <= fe_fin;
              if (bcnt == B_STOP) begin
                state <= IDLE;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      // An ack in the completion cycle frees the slot, so the new frame loads without overrun.
      if (done && (!data_valid || data_ack)) begin
        data_out     <= sr;
        parity_error <= pe_r;
        frame_error  <= fe_fin;
        data_valid   <= 1'b1;
        overrun      <= 1'b0;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule
